// File: rtl/ae_bank_writer.sv
// rtl/ae_bank_writer.sv - ping-pong bank writer for acoustic-emission event samples
// Streams one event into two alternating banks and hands each filled or closed bank to the readout.
module ae_bank_writer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 200,
  parameter int ADDR_W    = 8,
  parameter int MAX_BANKS = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              readout_busy,
  output logic              we,
  output logic [ADDR_W:0]   addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              bank,
  output logic              bank0_full,
  output logic              bank1_full,
  output logic              memorization_completed,
  output logic [ADDR_W-1:0] idx_final,
  output logic [7:0]        dropped_events
);

  typedef enum logic [1:0] {IDLE, WRITE, CLOSE, DONE} state_t;

  localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        BANK_LIMIT = 8'(MAX_BANKS);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        bank_cnt;
  logic              trigger_d;
  logic              last_idx;
  logic              start_event;
  logic              dropped_edge;

  assign last_idx     = (idx == IDX_LAST);
  assign start_event  = trigger && !readout_busy;
  assign dropped_edge = trigger && !trigger_d && readout_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_event) state_nxt = WRITE;
      WRITE:   if (!trigger || bank_cnt == BANK_LIMIT) state_nxt = CLOSE;
      CLOSE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we                     <= 1'b0;
      addr_out               <= '0;
      data_out               <= '0;
      bank                   <= 1'b0;
      bank0_full             <= 1'b0;
      bank1_full             <= 1'b0;
      memorization_completed <= 1'b0;
      idx_final              <= '0;
      dropped_events         <= '0;
      idx                    <= '0;
      bank_cnt               <= '0;
      trigger_d              <= 1'b0;
    end else begin
      trigger_d              <= trigger;
      we                     <= 1'b0;
      bank0_full             <= 1'b0;
      bank1_full             <= 1'b0;
      memorization_completed <= 1'b0;
      case (state)
        IDLE: begin
          if (start_event) begin
            idx      <= '0;
            bank_cnt <= '0;
          end else if (dropped_edge && dropped_events != 8'hFF) begin
            dropped_events <= dropped_events + 8'd1;
          end
        end
        WRITE: begin
          // The sample of the closing cycle is still written, bank-full handling included.
          if (data_valid) begin
            we       <= 1'b1;
            addr_out <= {bank, idx};
            data_out <= data_in;
            if (last_idx) begin
              idx        <= '0;
              bank       <= ~bank;
              bank0_full <= ~bank;
              bank1_full <= bank;
              if (bank_cnt != 8'hFF) bank_cnt <= bank_cnt + 8'd1;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        CLOSE: begin
          // An empty final bank reports index 0; the readout then sends one stale word.
          idx_final <= (idx == '0) ? '0 : idx - ADDR_W'(1);
        end
        DONE: begin
          memorization_completed <= 1'b1;
          bank                   <= ~bank;
        end
        default: ;
      endcase
    end
  end

endmodule
